fft_frame_scheduler: RTL and testbench
======================================

Name: fft_frame_scheduler

Overview:
Sequencer wrapped around the 8-point high_speed_fft core. It collects a serial sample stream into an 8-sample frame and holds the frame stable on the core inputs. It restarts the core via the core's active-low reset, waits for core vld with a timeout, latches all 16 result words, then streams the bins out over a ready/valid interface. It is the only block that drives the core's x0..x7 and rstn pins.

Parameters:
WIDTH, 9, sample and result word width (matches core width)
TIMEOUT, 15, max cycles in WAIT before abort; 4-bit timer, legal range 1..15

Ports:
clk  input  1  clock; all logic rising-edge
rstn  input  1  asynchronous active-high reset (asserted = 1)
s_valid  input  1  input sample valid
s_ready  output  1  scheduler can accept sample
s_data  input  WIDTH  real input sample
fft_rstn_o  output  1  to core rstn (active-low); 0 = core held in reset
fft_x_o  output  8*WIDTH  frame to core; x0 = bits [WIDTH-1:0], xk = bits [(k+1)*WIDTH-1 : k*WIDTH]
fft_vld_i  input  1  core vld
fft_y_i  input  16*WIDTH  core results, order y0r,y0i,y1r,...,y7i, starting at LSB
m_valid  output  1  output bin valid
m_ready  input  1  downstream accepts bin
m_re  output  WIDTH  bin real part
m_im  output  WIDTH  bin imaginary part
m_idx  output  3  bin index 0..7
m_last  output  1  high with bin 7
busy  output  1  state != COLLECT
err_timeout  output  1  sticky; set on WAIT timeout

Behaviour:
- Reset (rstn=1, async): state=COLLECT, wr_idx=0, rd_idx=0, timer=0, frame/result registers=0, err_timeout=0, fft_rstn_o=0, m_valid=0, busy=0. s_ready is 0 while rstn=1.
- States: COLLECT -> KICK -> WAIT -> DRAIN -> COLLECT. WAIT -> COLLECT on timeout.
- COLLECT:
  - s_ready=1, fft_rstn_o=1.
  - Each s_valid&s_ready writes buf[wr_idx] and increments wr_idx.
  - The 8th accept (wr_idx=7) moves to KICK next cycle and wraps wr_idx to 0.
  - fft_x_o updates only on the KICK entry edge; it is stable otherwise.
- KICK: exactly 1 cycle. fft_rstn_o=0, s_ready=0. Clears timer. Always -> WAIT.
- WAIT:
  - fft_rstn_o=1, s_ready=0, timer increments each cycle.
  - fft_vld_i=1: latch fft_y_i into the result registers, -> DRAIN (vld takes priority over timeout in the same cycle).
  - timer==TIMEOUT with no vld: set err_timeout, discard frame, -> COLLECT.
  - vld seen during KICK is ignored.
- DRAIN:
  - m_valid=1; m_re/m_im/m_idx come from result bin rd_idx; m_last = (rd_idx==7).
  - On m_valid&m_ready, rd_idx increments.
  - Handshake with m_last -> COLLECT and rd_idx=0.
  - m_ready low stalls; outputs stay stable while m_valid&!m_ready.
- Output data is registered/stable; m_valid deasserts the cycle after the final handshake.
- err_timeout clears only on reset.
- Reset mid-operation: immediate return to reset values; the partial frame and pending bins are lost.
- Latency: last sample accept -> m_valid = 1 (KICK) + core latency + 1 cycle.

Optional Feature:
FFT_SCHED_OVERLAP_EN
- Defined:
  - Adds a second 8-entry shadow buffer. s_ready stays 1 in WAIT and DRAIN until the shadow buffer holds 8 samples.
  - On DRAIN exit with the shadow buffer full, go directly to KICK with the shadow frame.
  - On DRAIN exit with the shadow buffer partial, go to COLLECT and continue filling from the current count.
  - On WAIT timeout the shadow contents are retained.
- Undefined: no shadow buffer; s_ready=0 outside COLLECT.

Test Plan:
- Reset: hold rstn=1 for 2 cycles, check all outputs at reset values. Release and check s_ready=1, fft_rstn_o=1 next cycle.
- Frame 1,2,4,8,16,32,64,128 with the real core: fft_rstn_o low for exactly 1 cycle. Bins expected:
  - bin0 = 255 + j0
  - bin4 = -85 (9'h1AB) + j0
  - m_idx 0..7 in order, m_last only on idx 7.
- Backpressure: m_ready toggles 1,0,0,1,... Check no bin lost or duplicated and data held stable during stalls.
- Timeout: stub core with fft_vld_i tied 0. Expect err_timeout=1 exactly TIMEOUT cycles after WAIT entry, return to COLLECT, s_ready=1. err_timeout stays 1 through the next good frame.
- s_valid gaps: samples every 3rd cycle. Check fft_x_o matches sample order (x0 = first sample).
- Mid-drain reset: assert rstn at bin 3. Check m_valid=0 immediately (async). A fresh frame after release processes correctly.
- With FFT_SCHED_OVERLAP_EN: two back-to-back frames. Second frame samples are accepted during DRAIN of the first, and KICK follows the first frame's m_last handshake on the next cycle.

Source files
------------

// File: rtl/fft_frame_scheduler_if.sv
// fft_frame_scheduler_if: bundles the sample input stream, the bin output stream
// and the pins that connect the scheduler to the 8-point FFT core.
// master = scheduler side; slave = surrounding environment (source, sink, core).
interface fft_frame_scheduler_if #(
   parameter int WIDTH = 9
);
   // sample stream in
   logic                 s_valid;
   logic                 s_ready;
   logic [WIDTH-1:0]     s_data;
   // FFT core pins
   logic                 fft_rstn_o;
   logic [8*WIDTH-1:0]   fft_x_o;
   logic                 fft_vld_i;
   logic [16*WIDTH-1:0]  fft_y_i;
   // bin stream out
   logic                 m_valid;
   logic                 m_ready;
   logic [WIDTH-1:0]     m_re;
   logic [WIDTH-1:0]     m_im;
   logic [2:0]           m_idx;
   logic                 m_last;
   // status
   logic                 busy;
   logic                 err_timeout;

   modport master (
      input  s_valid, s_data, fft_vld_i, fft_y_i, m_ready,
      output s_ready, fft_rstn_o, fft_x_o, m_valid, m_re, m_im, m_idx, m_last,
             busy, err_timeout
   );

   modport slave (
      output s_valid, s_data, fft_vld_i, fft_y_i, m_ready,
      input  s_ready, fft_rstn_o, fft_x_o, m_valid, m_re, m_im, m_idx, m_last,
             busy, err_timeout
   );
endinterface

// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: gathers 8 serial samples into a frame, restarts the FFT core on
//   it, waits (with timeout) for core vld, latches the 16 result words and streams the 8 bins.
// Latency: last sample accept -> m_valid = 1 (KICK) + core latency + 1 cycle.
// Backpressure: s_ready low outside COLLECT; m_ready low holds the current bin stable.
// Ports: clk, rstn (async, active-high despite the name), bus (fft_frame_scheduler_if.master:
//   s_* sample stream, fft_* core pins, m_* bin stream, busy, err_timeout).
// Option FFT_SCHED_OVERLAP_EN: keep accepting the next frame into a shadow buffer
//   during WAIT and DRAIN, and kick it straight after the current frame drains.
module fft_frame_scheduler #(
   parameter int WIDTH   = 9,
   parameter int TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rstn,
   fft_frame_scheduler_if.master bus
);
   localparam logic [1:0] COLLECT = 2'd0;
   localparam logic [1:0] KICK    = 2'd1;
   localparam logic [1:0] WAIT    = 2'd2;
   localparam logic [1:0] DRAIN   = 2'd3;

   localparam logic [3:0] TIMEOUT_L = 4'(TIMEOUT);

   logic [1:0]         state;
   logic [2:0]         wr_idx;
   logic [2:0]         rd_idx;
   logic [3:0]         timer;
   logic [3:0]         timer_inc;
   logic [WIDTH-1:0]   samp_q [8];
   logic [WIDTH-1:0]   res_q  [16];
   logic [8*WIDTH-1:0] x_q;
   logic               err_q;
   logic               acc;
   logic               last_acc;
   logic               frame_rdy;
   logic [8*WIDTH-1:0] frame_w;
`ifdef FFT_SCHED_OVERLAP_EN
   logic               full_q;   // shadow buffer holds a complete frame
`endif

   // Frame as it will look after this cycle's accept, so the 8th sample can be
   // forwarded to the core register on the same edge it is written.
   always_comb begin
      frame_w = '0;
      for (int k = 0; k < 8; k++) frame_w[k*WIDTH +: WIDTH] = samp_q[k];
      if (acc) frame_w[int'(wr_idx)*WIDTH +: WIDTH] = bus.s_data;
   end

`ifdef FFT_SCHED_OVERLAP_EN
   assign bus.s_ready = !rstn && (state != KICK) && !full_q;
   assign frame_rdy   = full_q || last_acc;
`else
   assign bus.s_ready = !rstn && (state == COLLECT);
   assign frame_rdy   = last_acc;
`endif

   assign acc       = bus.s_valid && bus.s_ready;
   assign last_acc  = acc && (wr_idx == 3'd7);
   assign timer_inc = timer + 4'd1;

   // Core is released whenever we are not kicking it; reset forces it held.
   assign bus.fft_rstn_o  = !rstn && (state != KICK);
   assign bus.fft_x_o     = x_q;
   assign bus.m_valid     = (state == DRAIN);
   assign bus.m_re        = res_q[{rd_idx, 1'b0}];
   assign bus.m_im        = res_q[{rd_idx, 1'b1}];
   assign bus.m_idx       = rd_idx;
   assign bus.m_last      = (state == DRAIN) && (rd_idx == 3'd7);
   assign bus.busy        = (state != COLLECT);
   assign bus.err_timeout = err_q;

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state  <= COLLECT;
         wr_idx <= '0;
         rd_idx <= '0;
         timer  <= '0;
         x_q    <= '0;
         err_q  <= 1'b0;
         for (int k = 0; k < 8; k++)  samp_q[k] <= '0;
         for (int k = 0; k < 16; k++) res_q[k]  <= '0;
`ifdef FFT_SCHED_OVERLAP_EN
         full_q <= 1'b0;
`endif
      end else begin
         // wr_idx wraps 7 -> 0 on its own after the 8th sample
         if (acc) begin
            samp_q[wr_idx] <= bus.s_data;
            wr_idx         <= wr_idx + 3'd1;
         end
`ifdef FFT_SCHED_OVERLAP_EN
         if (last_acc && (state != COLLECT)) full_q <= 1'b1;
`endif
         case (state)
            COLLECT: begin
               if (frame_rdy) begin
                  x_q   <= frame_w;
                  state <= KICK;
`ifdef FFT_SCHED_OVERLAP_EN
                  full_q <= 1'b0;
`endif
               end
            end
            KICK: begin
               timer <= '0;
               state <= WAIT;
            end
            WAIT: begin
               timer <= timer_inc;
               // vld wins over a timeout landing on the same cycle
               if (bus.fft_vld_i) begin
                  for (int k = 0; k < 16; k++) res_q[k] <= bus.fft_y_i[k*WIDTH +: WIDTH];
                  state <= DRAIN;
               end else if (timer_inc == TIMEOUT_L) begin
                  // abort exactly TIMEOUT cycles after entering WAIT
                  err_q <= 1'b1;
                  state <= COLLECT;
               end
            end
            DRAIN: begin
               if (bus.m_ready) begin
                  rd_idx <= rd_idx + 3'd1;
                  if (rd_idx == 3'd7) begin
                     state <= COLLECT;
`ifdef FFT_SCHED_OVERLAP_EN
                     if (frame_rdy) begin
                        x_q    <= frame_w;
                        state  <= KICK;
                        full_q <= 1'b0;
                     end
`endif
                  end
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// tb_fft_frame_scheduler: drives random sample frames through the scheduler with a
// behavioural FFT core stub, and checks frame order, kick pulse, latency, bins,
// backpressure stability, timeout and asynchronous reset behaviour.
module tb_fft_frame_scheduler;
   localparam int  W        = 9;
   localparam int  TO       = 15;
   localparam int  CORE_LAT = 3;
   localparam real PI       = 3.14159265358979;

   logic clk;
   logic rstn;
   bit   core_en;
   int   core_cnt;
   int   checks   = 0;
   int   failures = 0;
   logic [W-1:0] got_re [8];
   logic [W-1:0] got_im [8];

   fft_frame_scheduler_if #(.WIDTH(W)) bus ();

   fft_frame_scheduler #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference arithmetic ----------------
   function automatic logic [8*W-1:0] pack(input logic [W-1:0] smp [8]);
      logic [8*W-1:0] p;
      p = '0;
      for (int k = 0; k < 8; k++) p[k*W +: W] = smp[k];
      return p;
   endfunction

   function automatic int rnd(input real r);
      return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
   endfunction

   // 8-point DFT of signed samples, rounded and wrapped to W bits
   function automatic logic [16*W-1:0] dft(input logic [8*W-1:0] x);
      logic [16*W-1:0] y;
      real re, im, a, v;
      y = '0;
      for (int k = 0; k < 8; k++) begin
         re = 0.0;
         im = 0.0;
         for (int n = 0; n < 8; n++) begin
            a  = 2.0 * PI * k * n / 8.0;
            v  = $itor($signed(x[n*W +: W]));
            re = re + v * $cos(a);
            im = im - v * $sin(a);
         end
         y[(2*k)*W +: W]   = W'(rnd(re));
         y[(2*k+1)*W +: W] = W'(rnd(im));
      end
      return y;
   endfunction

   // ---------------- FFT core stub ----------------
   always @(posedge clk or negedge bus.fft_rstn_o) begin
      if (bus.fft_rstn_o !== 1'b1) core_cnt <= 0;
      else if (core_cnt < CORE_LAT) core_cnt <= core_cnt + 1;
   end
   assign bus.fft_vld_i = core_en && (core_cnt == CORE_LAT);
   assign bus.fft_y_i   = dft(bus.fft_x_o);

   // ---------------- stimulus helpers ----------------
   task automatic rand_frame(output logic [W-1:0] smp [8]);
      for (int k = 0; k < 8; k++) smp[k] = W'($urandom_range(62, 0)) - W'(31);
   endtask

   // called at a negedge; returns at the negedge after the accepting posedge
   task automatic push(input logic [W-1:0] d);
      int n;
      n = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      while (bus.s_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      bus.s_valid = 1'b0;
      if (n >= 100) begin
         checks++;
         failures++;
         $display("FAIL push_timeout s_ready=%b required=1", bus.s_ready);
      end
   endtask

   task automatic push_frame(input logic [W-1:0] smp [8], input int gap);
      for (int i = 0; i < 8; i++) begin
         repeat (gap) @(negedge clk);
         push(smp[i]);
      end
   endtask

   task automatic drain_check(input logic [W-1:0] smp [8], input int pat);
      logic [16*W-1:0] y;
      logic [W-1:0] hr, hi;
      logic [2:0] hx;
      int idx, cyc;
      bit stall;
      y = dft(pack(smp));
      idx = 0; cyc = 0; stall = 0; hr = '0; hi = '0; hx = '0;
      while (idx < 8 && cyc < 300) begin
         if (bus.m_valid === 1'b1) begin
            if (stall) begin
               checks++;
               if (bus.m_re !== hr || bus.m_im !== hi || bus.m_idx !== hx) begin
                  failures++;
                  $display("FAIL stall_hold got=%h/%h/%0d required=%h/%h/%0d",
                           bus.m_re, bus.m_im, bus.m_idx, hr, hi, hx);
               end
            end
            if (pat == 0)      bus.m_ready = 1'b1;
            else if (pat == 1) bus.m_ready = (cyc % 3 == 0);
            else               bus.m_ready = 1'($urandom_range(1, 0));
            if (bus.m_ready) begin
               checks++;
               if (bus.m_idx !== 3'(idx) || bus.m_re !== y[(2*idx)*W +: W] ||
                   bus.m_im !== y[(2*idx+1)*W +: W] || bus.m_last !== (idx == 7)) begin
                  failures++;
                  $display("FAIL bin got idx=%0d re=%h im=%h last=%b required idx=%0d re=%h im=%h last=%b",
                           bus.m_idx, bus.m_re, bus.m_im, bus.m_last,
                           idx, y[(2*idx)*W +: W], y[(2*idx+1)*W +: W], idx == 7);
               end
               got_re[idx] = bus.m_re;
               got_im[idx] = bus.m_im;
               idx++;
               stall = 0;
            end else begin
               stall = 1;
               hr = bus.m_re; hi = bus.m_im; hx = bus.m_idx;
            end
         end else begin
            bus.m_ready = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      bus.m_ready = 1'b0;
      checks++;
      if (idx != 8) begin
         failures++;
         $display("FAIL drain_timeout bins=%0d required=8", idx);
      end
      checks++;
      if (bus.m_valid !== 1'b0 || bus.busy !== 1'b0 || bus.s_ready !== 1'b1) begin
         failures++;
         $display("FAIL after_last m_valid=%b busy=%b s_ready=%b required 0/0/1",
                  bus.m_valid, bus.busy, bus.s_ready);
      end
   endtask

   task automatic run_frame(input logic [W-1:0] smp [8], input int gap, input int pat);
      int n;
      bus.m_ready = 1'b0;
      push_frame(smp, gap);
      // now in the cycle right after the 8th accept: KICK
      checks++;
      if (bus.fft_rstn_o !== 1'b0 || bus.s_ready !== 1'b0 || bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL kick_state fft_rstn_o=%b s_ready=%b busy=%b required 0/0/1",
                  bus.fft_rstn_o, bus.s_ready, bus.busy);
      end
      checks++;
      if (bus.fft_x_o !== pack(smp)) begin
         failures++;
         $display("FAIL frame_order got=%h required=%h", bus.fft_x_o, pack(smp));
      end
      n = 0;
      while (bus.m_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            checks++;
            if (bus.fft_rstn_o !== 1'b1) begin
               failures++;
               $display("FAIL kick_width fft_rstn_o=%b required=1", bus.fft_rstn_o);
            end
         end
      end
      checks++;
      if (n != 2 + CORE_LAT) begin
         failures++;
         $display("FAIL latency got=%0d required=%0d", n, 2 + CORE_LAT);
      end
      drain_check(smp, pat);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.s_ready !== 1'b0 || bus.fft_rstn_o !== 1'b0 || bus.m_valid !== 1'b0 ||
          bus.busy !== 1'b0 || bus.err_timeout !== 1'b0 || bus.m_last !== 1'b0 ||
          bus.m_idx !== 3'd0 || bus.fft_x_o !== '0) begin
         failures++;
         $display("FAIL reset_values s_ready=%b fft_rstn_o=%b m_valid=%b busy=%b err=%b last=%b idx=%0d x=%h required all 0",
                  bus.s_ready, bus.fft_rstn_o, bus.m_valid, bus.busy, bus.err_timeout,
                  bus.m_last, bus.m_idx, bus.fft_x_o);
      end
      rstn = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.s_ready !== 1'b1 || bus.fft_rstn_o !== 1'b1 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL release s_ready=%b fft_rstn_o=%b busy=%b required 1/1/0",
                  bus.s_ready, bus.fft_rstn_o, bus.busy);
      end
   endtask

   task automatic test_known_frame();
      logic [W-1:0] smp [8];
      for (int k = 0; k < 8; k++) smp[k] = W'(1 << k);
      run_frame(smp, 0, 0);
      checks++;
      if (got_re[0] !== 9'd255 || got_im[0] !== 9'd0) begin
         failures++;
         $display("FAIL bin0_const got=%h/%h required=0ff/000", got_re[0], got_im[0]);
      end
      checks++;
      if (got_re[4] !== 9'h1AB || got_im[4] !== 9'd0) begin
         failures++;
         $display("FAIL bin4_const got=%h/%h required=1ab/000", got_re[4], got_im[4]);
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] smp [8];
      for (int r = 0; r < 2; r++) begin
         rand_frame(smp);
         run_frame(smp, 0, 1);
      end
   endtask

   task automatic test_gaps();
      logic [W-1:0] smp [8];
      for (int r = 0; r < 2; r++) begin
         rand_frame(smp);
         run_frame(smp, 2, 2);
      end
   endtask

   task automatic test_timeout();
      logic [W-1:0] smp [8];
      int n;
      core_en = 1'b0;
      rand_frame(smp);
      push_frame(smp, 0);
      n = 0;
      while (bus.err_timeout !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      // WAIT is entered one edge after this KICK cycle; abort TO edges later
      checks++;
      if (n != TO + 1) begin
         failures++;
         $display("FAIL timeout_time got=%0d required=%0d", n, TO + 1);
      end
      checks++;
      if (bus.s_ready !== 1'b1 || bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin
         failures++;
         $display("FAIL timeout_return s_ready=%b busy=%b m_valid=%b required 1/0/0",
                  bus.s_ready, bus.busy, bus.m_valid);
      end
      core_en = 1'b1;
      rand_frame(smp);
      run_frame(smp, 0, 0);
      checks++;
      if (bus.err_timeout !== 1'b1) begin
         failures++;
         $display("FAIL err_sticky got=%b required=1", bus.err_timeout);
      end
   endtask

   task automatic test_mid_drain_reset();
      logic [W-1:0] smp [8];
      int n;
      rand_frame(smp);
      bus.m_ready = 1'b0;
      push_frame(smp, 0);
      n = 0;
      while (!(bus.m_valid === 1'b1 && bus.m_idx === 3'd3) && n < 100) begin
         bus.m_ready = 1'b1;
         @(negedge clk);
         n++;
      end
      bus.m_ready = 1'b0;
      checks++;
      if (n >= 100) begin
         failures++;
         $display("FAIL reach_bin3 idx=%0d required=3", bus.m_idx);
      end
      rstn = 1'b1;
      #1;
      checks++;
      if (bus.m_valid !== 1'b0 || bus.fft_rstn_o !== 1'b0 || bus.s_ready !== 1'b0 ||
          bus.busy !== 1'b0 || bus.err_timeout !== 1'b0) begin
         failures++;
         $display("FAIL async_reset m_valid=%b fft_rstn_o=%b s_ready=%b busy=%b err=%b required all 0",
                  bus.m_valid, bus.fft_rstn_o, bus.s_ready, bus.busy, bus.err_timeout);
      end
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rand_frame(smp);
      run_frame(smp, 0, 2);
   endtask

`ifdef FFT_SCHED_OVERLAP_EN
   task automatic test_back_to_back();
      logic [W-1:0] a [8];
      logic [W-1:0] b [8];
      int t_last, t_kick, cyc;
      rand_frame(a);
      rand_frame(b);
      t_last = -1; t_kick = -1; cyc = 0;
      bus.m_ready = 1'b1;
      fork
         begin
            push_frame(a, 0);
            push_frame(b, 0);
         end
         begin
            while (cyc < 300 && t_kick < 0) begin
               @(negedge clk);
               cyc++;
               if (bus.m_valid === 1'b1 && bus.m_last === 1'b1 && t_last < 0) t_last = cyc;
               else if (t_last >= 0 && bus.fft_rstn_o === 1'b0) t_kick = cyc;
            end
         end
      join
      bus.m_ready = 1'b0;
      checks++;
      if (t_last < 0 || t_kick != t_last + 1) begin
         failures++;
         $display("FAIL overlap_kick got=%0d required=%0d", t_kick, t_last + 1);
      end
      checks++;
      if (bus.fft_x_o !== pack(b)) begin
         failures++;
         $display("FAIL overlap_frame got=%h required=%h", bus.fft_x_o, pack(b));
      end
      drain_check(b, 0);
   endtask
`endif

   initial begin
      rstn        = 1'b1;
      core_en     = 1'b1;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.m_ready = 1'b0;
      test_reset();
      test_known_frame();
      test_backpressure();
      test_gaps();
      test_timeout();
      test_mid_drain_reset();
`ifdef FFT_SCHED_OVERLAP_EN
      test_back_to_back();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
